apb_completer_regfile: RTL
==========================

APB_COMPLETER_REGFILE -- requirements
Module: apb_completer_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of 32-bit registers (power of two, 2..256).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, wait states inserted before pready (0..15).
REQ-003 SHALL have parameter ID_VALUE, default 32'hA9B0_0001, read-only contents of register 0.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: pclk input 1, the sole clock, all state on rising edge.
REQ-005 prst  input  1  reset, asynchronous assert, active-high.
REQ-006 psel  input  1  completer selected.
REQ-007 penable  input  1  access phase indicator.
REQ-008 pwrite  input  1  1 = write, 0 = read.
REQ-009 paddr  input  32  word index (not byte address).
REQ-010 pwdata  input  32  write data.
REQ-011 prdata  output  32  read data, valid only while pready=1.
REQ-012 pready  output  1  transfer completes this cycle.
REQ-013 pslverr  output  1  error response, valid only while pready=1.

Function
REQ-014 FSM states SHALL be IDLE, ACCESS; one transfer in flight at most.
REQ-015 IDLE: psel=1 and penable=0 (setup phase) SHALL latch paddr, pwrite, pwdata, load wait counter with WAIT_CYCLES, go to ACCESS.
REQ-016 IDLE: psel=1 and penable=1 (no prior setup) SHALL be ignored; stay IDLE, pready=0.
REQ-017 ACCESS with psel=1, penable=1 and counter>0 SHALL decrement counter, pready=0.
REQ-018 ACCESS with counter=0 SHALL drive pready=1 combinationally for exactly one cycle, then return to IDLE.
REQ-019 Latency: pready SHALL rise WAIT_CYCLES+1 cycles after the setup-phase edge (WAIT_CYCLES=0 -> first access cycle).
REQ-020 ACCESS with psel=0 or penable=0 (protocol abort) SHALL return to IDLE, no write, no pready.
REQ-021 Error condition: latched address >= NUM_REGS, or write to index 0; SHALL set pslverr=1 with pready.
REQ-022 Write SHALL commit pwdata (latched) to register at the pready edge only when no error.
REQ-023 Read SHALL drive prdata = register[addr] (index 0 -> ID_VALUE) with pready; error reads SHALL give prdata=0.
REQ-024 prdata SHALL be 0 and pslverr 0 whenever pready=0.
REQ-025 Address compare SHALL use full 32-bit paddr; no aliasing of upper bits.
REQ-026 Back-to-back: setup phase in the cycle after pready SHALL be accepted with no dead cycle.
REQ-027 Read of an address in the same transfer sequence after a write SHALL return the newly written value.

Reset
REQ-028 prst=1 SHALL immediately force FSM to IDLE, counter 0, pready=0, pslverr=0, prdata=0.
REQ-029 prst SHALL clear registers 1..NUM_REGS-1 to 0; reset mid-transfer SHALL discard the pending write.

Structure
REQ-030 Package apb_pkg SHALL hold FSM state enum, APB_DATA_W=32, APB_ADDR_W=32, default ID constant.
REQ-031 Storage SHALL be a sub-module apb_regfile (sync write port, async read port, async clear); FSM/decode in top.

Verification
REQ-032 Reset then read idx 0 -> pready after 2 cycles (WAIT_CYCLES=1), prdata=32'hA9B0_0001, pslverr=0.
REQ-033 Write idx 1..10 with 152,1002,9528,4858,88,8475,1088,5845,8500,6258, then read idx 4..9 -> 4858,88,8475,1088,5845,8500.
REQ-034 Write idx 16 (NUM_REGS=16) value 32'hDEAD -> pslverr=1; read idx 16 -> prdata=0, pslverr=1.
REQ-035 Write idx 0 value 5 -> pslverr=1; subsequent read idx 0 -> ID_VALUE unchanged.
REQ-036 WAIT_CYCLES=0 back-to-back write idx 3=7 then read idx 3 -> each pready in first access cycle, read prdata=7.
REQ-037 Write idx 2=99, assert prst during ACCESS -> pready never asserts; after reset read idx 2 -> 0; also psel drop mid-ACCESS -> no write.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB completer register file.
package apb_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_ADDR_W = 32;
    localparam int APB_WAIT_W = 4;
    localparam logic [APB_DATA_W-1:0] APB_DEFAULT_ID = 32'hA9B0_0001;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } apb_state_e;

endpackage

// File: rtl/apb_regfile.sv
// Register storage: synchronous write port, asynchronous read port, async clear.
module apb_regfile
    import apb_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [APB_DATA_W-1:0] rdata
);

    logic [APB_DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/apb_completer_regfile.sv
// APB completer in front of a register file; register 0 is a read-only ID.
module apb_completer_regfile
    import apb_pkg::*;
#(
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_CYCLES = 1,
    parameter logic [APB_DATA_W-1:0] ID_VALUE    = APB_DEFAULT_ID
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [APB_WAIT_W-1:0] CNT_INIT = APB_WAIT_W'(WAIT_CYCLES);

    apb_state_e            state;
    apb_state_e            state_next;
    logic [APB_WAIT_W-1:0] cnt;
    logic [APB_WAIT_W-1:0] cnt_next;

    logic [APB_ADDR_W-1:0] addr_q;
    logic [APB_DATA_W-1:0] wdata_q;
    logic                  write_q;

    logic                  setup;
    logic                  access_ok;
    logic                  done;
    logic                  err;
    logic                  rf_we;
    logic [APB_DATA_W-1:0] rf_rdata;

    assign setup     = psel && !penable;
    assign access_ok = psel && penable;

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Transfer context is captured only at an accepted setup phase.
    always_ff @(posedge pclk) begin
        if (state == ST_IDLE && setup) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (setup) begin
                    state_next = ST_ACCESS;
                    cnt_next   = CNT_INIT;
                end
            end
            ST_ACCESS: begin
                // A dropped psel/penable aborts the transfer without completing it.
                if (!access_ok) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Full-width compare so upper address bits never alias onto valid indices.
    assign err   = (addr_q >= APB_ADDR_W'(NUM_REGS)) || (write_q && addr_q == '0);
    assign rf_we = done && write_q && !err;

    apb_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk   (pclk),
        .rst   (prst),
        .we    (rf_we),
        .waddr (addr_q[IDX_W-1:0]),
        .wdata (wdata_q),
        .raddr (addr_q[IDX_W-1:0]),
        .rdata (rf_rdata)
    );

    assign pready  = done;
    assign pslverr = done && err;

    always_comb begin
        prdata = '0;
        if (done && !write_q && !err) begin
            prdata = (addr_q == '0) ? ID_VALUE : rf_rdata;
        end
    end

endmodule
